// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART constants: FSM state encodings and the 16x oversampling factor,
// common to the transmitter and the receiver.
package fifo_uart_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    localparam int OVERSAMPLE = 16;

    // Debug view of the transmitter FSM, exported for checkers.
    typedef struct packed {
        logic [1:0] state;
        logic [3:0] s;
        logic       busy;
    } tx_dbg_t;

    // Line level for a given state: low for the start bit, data LSB in DATA, high otherwise.
    function automatic logic line_level(input logic [1:0] st, input logic bit0);
        return (st == ST_DATA) ? bit0 : (st != ST_START);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port seen by the UART transmitter.
// Handshake: fifo_empty=0 means fifo_r_data is valid; fifo_rd is the pop strobe.
// A word moves on a rising clk edge where fifo_rd=1 and fifo_empty=0, never otherwise.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_r_data;
    logic                  fifo_rd;

    modport master (
        input  fifo_empty,
        input  fifo_r_data,
        output fifo_rd
    );

    modport slave (
        output fifo_empty,
        output fifo_r_data,
        input  fifo_rd
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a FIFO and serialises them LSB first
// with one start bit and a stop bit of SB_TICK oversampling ticks.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICK    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    fifo_uart_tx_if.master  fifo,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output tx_dbg_t         dbg
);

    localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    // The tick counter is 4 bits, so SB_TICK must not exceed 16.
    localparam logic [3:0]    S_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]    SB_LAST = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DATA_WIDTH - 1);

    logic [1:0]            state, state_next;
    logic [3:0]            s, s_next;
    logic [NW-1:0]         n, n_next;
    logic [DATA_WIDTH-1:0] b, b_next;
    logic                  tx_reg;

    always_comb begin
        state_next   = state;
        s_next       = s;
        n_next       = n;
        b_next       = b;
        fifo.fifo_rd = 1'b0;
        tx_done_tick = 1'b0;
        case (state)
            ST_IDLE: begin
                // The word is captured at pop time, so later FIFO writes cannot disturb the frame.
                if (!fifo.fifo_empty) begin
                    fifo.fifo_rd = 1'b1;
                    b_next       = fifo.fifo_r_data;
                    s_next       = 4'd0;
                    state_next   = ST_START;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        s_next     = 4'd0;
                        n_next     = '0;
                        state_next = ST_DATA;
                    end else begin
                        s_next = s + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        s_next = 4'd0;
                        b_next = b >> 1;
                        if (n == N_LAST) begin
                            state_next = ST_STOP;
                        end else begin
                            n_next = n + NW'(1);
                        end
                    end else begin
                        s_next = s + 4'd1;
                    end
                end
            end
            default: begin
                if (s_tick) begin
                    if (s == SB_LAST) begin
                        state_next   = ST_IDLE;
                        tx_done_tick = 1'b1;
                    end else begin
                        s_next = s + 4'd1;
                    end
                end
            end
        endcase
        if (reset) begin
            fifo.fifo_rd = 1'b0;
            tx_done_tick = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            s      <= 4'd0;
            n      <= '0;
            b      <= '0;
            tx_reg <= 1'b1;
        end else begin
            state  <= state_next;
            s      <= s_next;
            n      <= n_next;
            b      <= b_next;
            // Registered from the next state so tx tracks the state without lag or glitches.
            tx_reg <= line_level(state_next, b_next[0]);
        end
    end

    assign tx      = tx_reg;
    assign tx_busy = (state != ST_IDLE);
    assign dbg     = '{state: state, s: s, busy: tx_busy};

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, frame decoder and expected-word scoreboard.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
    import fifo_uart_tx_pkg::*;

    localparam int DW  = 8;
    localparam int SBT = 16;

    logic    clk = 1'b0;
    logic    reset = 1'b1;
    logic    s_tick = 1'b0;
    logic    tx, tx_busy, tx_done_tick;
    tx_dbg_t dbg;

    fifo_uart_tx_if #(.DATA_WIDTH(DW)) fif ();

    fifo_uart_tx #(.DATA_WIDTH(DW), .SB_TICK(SBT)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .fifo         (fif),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .dbg          (dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- check task ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- FIFO model and tick generator ----------------
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int rd_count = 0;
    int tick_div = 1;
    int tick_cnt = 0;

    task automatic fifo_refresh();
        fif.fifo_empty  = (fq.size() == 0);
        fif.fifo_r_data = (fq.size() == 0) ? '0 : fq[0];
    endtask

    always @(posedge clk) begin
        if (fif.fifo_rd === 1'b1) begin
            if (fq.size() > 0) void'(fq.pop_front());
            rd_count++;
        end
    end

    // Inputs change 1 ns after the edge and are therefore stable for the next edge.
    always @(posedge clk) begin
        #1;
        fifo_refresh();
        s_tick   = (tick_cnt == 0);
        tick_cnt = (tick_cnt + 1 >= tick_div) ? 0 : tick_cnt + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [DW-1:0] d);
        fq.push_back(d);
        exp_q.push_back(d);
        fifo_refresh();
    endtask

    // Push in a slot where the upcoming edge carries a tick, so START begins phase-aligned.
    task automatic push_aligned(input logic [DW-1:0] d);
        int g = 0;
        do begin
            @(posedge clk);
            #2;
            g++;
        end while (s_tick !== 1'b1 && g < 16);
        push_byte(d);
    endtask

    // ---------------- monitor / frame decoder ----------------
    bit            in_frame = 0;
    bit            post_end = 0;
    int            cnt, frame_len, per, k, pos;
    int            cyc = 0;
    int            end_cyc = -100;
    int            last_gap = -1;
    int            frames = 0;
    int            viol = 0;
    int            stray_done = 0;
    int            done_cnt, done_pos;
    logic          cur_bit, start_bit, glitch, busy_bad;
    logic [DW-1:0] dec, exp_word;

    always @(negedge clk) begin
        cyc++;
        if (fif.fifo_rd === 1'b1 && (fif.fifo_empty === 1'b1 || reset)) viol++;
        if (reset && tx_done_tick !== 1'b0) viol++;
        if (reset) begin
            in_frame = 0;
            post_end = 0;
        end else begin
            if (post_end) begin
                check_eq("busy_after_frame", tx_busy, 0);
                check_eq("tx_after_frame", tx, 1);
                post_end = 0;
            end
            if (!in_frame && tx === 1'b0) begin
                in_frame  = 1;
                cnt       = 0;
                per       = OVERSAMPLE * tick_div;
                frame_len = (DW + 1) * per + SBT * tick_div;
                glitch    = 0;
                busy_bad  = 0;
                done_cnt  = 0;
                done_pos  = -1;
                dec       = '0;
                last_gap  = cyc - end_cyc - 1;
            end else if (!in_frame && tx_done_tick === 1'b1) begin
                stray_done++;
            end
            if (in_frame) begin
                k   = cnt / per;
                pos = cnt % per;
                if (pos == 0) begin
                    cur_bit = tx;
                    if (k == 0) start_bit = tx;
                    else if (k <= DW) dec[k-1] = tx;
                end else if (tx !== cur_bit) begin
                    glitch = 1;
                end
                if (tx_busy !== 1'b1) busy_bad = 1;
                if (tx_done_tick === 1'b1) begin
                    done_cnt++;
                    done_pos = cnt;
                end
                if (cnt == frame_len - 1) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_frame", 1, 0);
                    end else begin
                        exp_word = exp_q.pop_front();
                        check_eq("frame_data", dec, exp_word);
                    end
                    check_eq("start_bit", start_bit, 0);
                    check_eq("stop_bit", cur_bit, 1);
                    check_eq("bit_stable", glitch, 0);
                    check_eq("busy_in_frame", busy_bad, 0);
                    check_eq("done_count", done_cnt, 1);
                    check_eq("done_pos", done_pos, frame_len - 1);
                    frames++;
                    in_frame = 0;
                    post_end = 1;
                    end_cyc  = cyc;
                end
                cnt++;
            end
        end
    end

    task automatic wait_frames(input int target, input int budget);
        int c = 0;
        while (frames < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_eq("frame_timeout", (frames >= target), 1);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_in_frame(input int min_cnt);
        int c = 0;
        while (!(in_frame && cnt >= min_cnt) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check_eq("in_frame_timeout", (in_frame && cnt >= min_cnt), 1);
        @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    int idle_bad = 0;
    int rd_base, frame_base;

    initial begin
        fif.fifo_empty  = 1'b1;
        fif.fifo_r_data = '0;
        reset = 1'b1;

        // Reset and idle line.
        repeat (3) begin
            @(negedge clk);
            if (tx !== 1'b1 || fif.fifo_rd !== 1'b0 || tx_busy !== 1'b0) idle_bad++;
        end
        check_eq("reset_state", dbg.state, ST_IDLE);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || fif.fifo_rd !== 1'b0 || tx_busy !== 1'b0) idle_bad++;
        end
        check_eq("idle_hold", idle_bad, 0);
        check_eq("idle_no_pop", rd_count, 0);

        // Single byte.
        rd_base = rd_count;
        push_aligned(8'hA5);
        wait_frames(1, 400);
        check_eq("single_pops", rd_count - rd_base, 1);

        // Back-to-back frames.
        rd_base = rd_count;
        push_aligned(8'h00);
        push_byte(8'hFF);
        wait_frames(3, 600);
        check_eq("b2b_gap", last_gap, 1);
        check_eq("b2b_pops", rd_count - rd_base, 2);
        check_eq("b2b_empty", fif.fifo_empty, 1);

        // Slow tick, one tick every 4 clks.
        tick_div = 4;
        tick_cnt = 0;
        push_aligned(8'h3C);
        wait_frames(4, 1200);
        tick_div = 1;
        tick_cnt = 0;

        // Reset during data bit 3.
        frame_base = frames;
        push_aligned(8'h55);
        push_byte(8'h66);
        wait_in_frame(OVERSAMPLE * 4 + 5);
        reset = 1'b1;
        rd_base = rd_count;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_tx_high", tx, 1);
        check_eq("rst_state", dbg.state, ST_IDLE);
        void'(exp_q.pop_front());
        repeat (4) @(posedge clk);
        #2;
        check_eq("rst_no_pop", rd_count - rd_base, 0);
        check_eq("rst_abort_frames", frames - frame_base, 0);
        reset = 1'b0;
        wait_frames(frame_base + 1, 400);
        check_eq("rst_next_pop", rd_count - rd_base, 1);

        // FIFO write while a frame is in flight.
        frame_base = frames;
        push_aligned(8'h34);
        wait_in_frame(40);
        push_byte(8'h12);
        wait_frames(frame_base + 2, 600);
        check_eq("wdf_gap", last_gap, 1);

        repeat (20) @(posedge clk);
        check_eq("exp_q_empty", exp_q.size(), 0);
        check_eq("fifo_model_empty", fq.size(), 0);
        check_eq("rd_violations", viol, 0);
        check_eq("stray_done", stray_done, 0);
        check_eq("frame_count", frames, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
